uart_rx_ctrl: RTL and testbench

- Controller that sequences the UART receive datapath.
- Generates the 16x oversample strobe from a programmable divisor and gates the receiver enable.
- Arms the receiver only after the line has been idle, captures completed bytes into a small FIFO, and hands them to the host over valid/ready.
- Sits between the receiver core and the MCU bus side.

---
 rtl/uart_pkg.sv | 13 +
 rtl/uart_rx_fifo.sv | 74 +++++++
 rtl/uart_rx_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

    typedef enum logic [1:0] {
        OFF = 2'd0,
        ARM = 2'd1,
        RUN = 2'd2
    } rx_ctrl_state_t;

    localparam int unsigned UART_OVERSAMPLE = 16;
    localparam int unsigned UART_DATA_W     = 8;

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word fall-through receive FIFO with registered head and valid.
// Pointers carry one extra MSB so full and empty are told apart by level.
module uart_rx_fifo #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic [DATA_W-1:0]             push_data,
    input  logic                          pop,
    output logic                          valid,
    output logic [DATA_W-1:0]             data,
    output logic [$clog2(FIFO_DEPTH):0]   level_c,
    output logic                          full_c
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]     wptr;
    logic [PW-1:0]     rptr;
    logic [PW-1:0]     wptr_n;
    logic [PW-1:0]     rptr_n;
    logic              empty_c;
    logic              do_pop_c;
    logic              do_push_c;
    logic [DATA_W-1:0] head_n;

    assign level_c   = wptr - rptr;
    assign full_c    = (level_c == PW'(FIFO_DEPTH));
    assign empty_c   = (wptr == rptr);
    assign do_pop_c  = pop && !empty_c;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push_c = push && (!full_c || do_pop_c);
    assign wptr_n    = wptr + PW'(do_push_c);
    assign rptr_n    = rptr + PW'(do_pop_c);

    // Next head: the incoming byte when it lands in the head slot, else storage.
    always_comb begin
        head_n = data;
        if (wptr_n != rptr_n) begin
            if (do_push_c && (rptr_n[AW-1:0] == wptr[AW-1:0])) begin
                head_n = push_data;
            end else begin
                head_n = mem[rptr_n[AW-1:0]];
            end
        end
    end

    // Storage write port.
    always_ff @(posedge clk) begin
        if (do_push_c) begin
            mem[wptr[AW-1:0]] <= push_data;
        end
    end

    // Pointers and registered head; data holds its value once empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            valid <= 1'b0;
            data  <= '0;
        end else begin
            wptr  <= wptr_n;
            rptr  <= rptr_n;
            valid <= (wptr_n != rptr_n);
            data  <= head_n;
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: oversample tick generation, idle-qualified
// receiver arming, byte capture into a FIFO and host hand-off.
// Optional receive-idle timeout is enabled by defining UART_RX_TIMEOUT_EN.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned DATA_W        = UART_DATA_W,
    parameter int unsigned DIV_W         = 16,
    parameter int unsigned FIFO_DEPTH    = 4,
    parameter int unsigned OVERSAMPLE    = UART_OVERSAMPLE,
    parameter int unsigned TIMEOUT_TICKS = 640
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cfg_en,
    input  logic [DIV_W-1:0]            cfg_div,
    input  logic                        rx_line,
    output logic                        rx_tick,
    output logic                        rx_ena,
    input  logic                        rx_done,
    input  logic [DATA_W-1:0]           rx_data,
    output logic                        m_valid,
    output logic [DATA_W-1:0]           m_data,
    input  logic                        m_ready,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        overrun,
    input  logic                        clr_overrun,
    output logic                        rx_timeout
);

    localparam int unsigned IDLE_W = $clog2(OVERSAMPLE + 1);

    rx_ctrl_state_t    state;
    logic [IDLE_W-1:0] idle_cnt;
    logic [DIV_W-1:0]  tick_cnt;
    logic [DIV_W-1:0]  div_q;
    logic [DIV_W-1:0]  div_eff_c;
    logic              line_s1;
    logic              line_s2;
    logic              done_s1;
    logic              done_s2;
    logic              done_q;
    logic              done_rise_c;
    logic              push_req_c;
    logic              pop_c;
    logic              full_c;
    logic              ovr_evt_c;

    // Two-flop synchronizers plus a delayed copy for rx_done edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_s1 <= 1'b1;
            line_s2 <= 1'b1;
            done_s1 <= 1'b0;
            done_s2 <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            line_s1 <= rx_line;
            line_s2 <= line_s1;
            done_s1 <= rx_done;
            done_s2 <= done_s1;
            done_q  <= done_s2;
        end
    end

    assign done_rise_c = done_s2 && !done_q;
    assign div_eff_c   = (cfg_div == '0) ? DIV_W'(1) : cfg_div;

    // Oversample tick generator; the divisor is re-latched only at a wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt <= '0;
            div_q    <= DIV_W'(1);
            rx_tick  <= 1'b0;
        end else if (state == OFF) begin
            tick_cnt <= '0;
            div_q    <= div_eff_c;
            rx_tick  <= 1'b0;
        end else if (tick_cnt == div_q - DIV_W'(1)) begin
            tick_cnt <= '0;
            div_q    <= div_eff_c;
            rx_tick  <= 1'b1;
        end else begin
            tick_cnt <= tick_cnt + DIV_W'(1);
            rx_tick  <= 1'b0;
        end
    end

    // Control FSM: arm only after OVERSAMPLE consecutive idle-high ticks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= OFF;
            idle_cnt <= '0;
            rx_ena   <= 1'b0;
        end else if (!cfg_en) begin
            state    <= OFF;
            idle_cnt <= '0;
            rx_ena   <= 1'b0;
        end else begin
            case (state)
                OFF: begin
                    state    <= ARM;
                    idle_cnt <= '0;
                    rx_ena   <= 1'b0;
                end
                ARM: begin
                    rx_ena <= 1'b0;
                    if (!line_s2) begin
                        idle_cnt <= '0;
                    end else if (rx_tick) begin
                        if (idle_cnt == IDLE_W'(OVERSAMPLE - 1)) begin
                            state    <= RUN;
                            idle_cnt <= '0;
                            rx_ena   <= 1'b1;
                        end else begin
                            idle_cnt <= idle_cnt + IDLE_W'(1);
                        end
                    end
                end
                RUN: begin
                    rx_ena <= 1'b1;
                end
                default: begin
                    state    <= OFF;
                    idle_cnt <= '0;
                    rx_ena   <= 1'b0;
                end
            endcase
        end
    end

    assign push_req_c = done_rise_c && (state == RUN);
    assign pop_c      = m_valid && m_ready;
    assign ovr_evt_c  = push_req_c && full_c && !pop_c;

    uart_rx_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_req_c),
        .push_data (rx_data),
        .pop       (m_ready),
        .valid     (m_valid),
        .data      (m_data),
        .level_c   (fifo_level),
        .full_c    (full_c)
    );

    // Sticky overrun; a drop in the clearing cycle keeps the flag set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun <= 1'b0;
        end else if (ovr_evt_c) begin
            overrun <= 1'b1;
        end else if (clr_overrun) begin
            overrun <= 1'b0;
        end
    end

`ifdef UART_RX_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_TICKS + 1);

    logic [TO_W-1:0] idle_ticks;
    logic            push_ok_c;

    assign push_ok_c = push_req_c && (!full_c || pop_c);

    // Saturating idle-tick counter while bytes wait unread in the FIFO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_ticks <= '0;
            rx_timeout <= 1'b0;
        end else if (push_ok_c || (fifo_level == '0)) begin
            idle_ticks <= '0;
            rx_timeout <= 1'b0;
        end else begin
            if (rx_tick && (idle_ticks != TO_W'(TIMEOUT_TICKS))) begin
                idle_ticks <= idle_ticks + TO_W'(1);
            end
            rx_timeout <= (idle_ticks == TO_W'(TIMEOUT_TICKS));
        end
    end
`else
    logic unused_timeout;

    assign unused_timeout = ^32'(TIMEOUT_TICKS);
    assign rx_timeout     = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl: expected bytes are queued as they are
// sent, and a monitor compares every host pop against the queue head.
module tb_uart_rx_ctrl;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned DIV_W  = 16;
    localparam int unsigned DEPTH  = 4;

    logic              clk;
    logic              rst;
    logic              cfg_en;
    logic [DIV_W-1:0]  cfg_div;
    logic              rx_line;
    logic              rx_tick;
    logic              rx_ena;
    logic              rx_done;
    logic [DATA_W-1:0] rx_data;
    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    logic              m_ready;
    logic [2:0]        fifo_level;
    logic              overrun;
    logic              clr_overrun;
    logic              rx_timeout;

    int                n_checks = 0;
    int                n_fail   = 0;
    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] mon_e;
    logic [DATA_W-1:0] d;
    int                ticks;
    int                cyc;
    int                last_tick;
    int                tick16_cyc;
    int                n_bytes;
    bit                acc;
    bit                ovr_exp;
    bit                timeout_exp;

    uart_rx_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_en      (cfg_en),
        .cfg_div     (cfg_div),
        .rx_line     (rx_line),
        .rx_tick     (rx_tick),
        .rx_ena      (rx_ena),
        .rx_done     (rx_done),
        .rx_data     (rx_data),
        .m_valid     (m_valid),
        .m_data      (m_data),
        .m_ready     (m_ready),
        .fifo_level  (fifo_level),
        .overrun     (overrun),
        .clr_overrun (clr_overrun),
        .rx_timeout  (rx_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Monitor: a pop happens at the next rising edge whenever valid and ready.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!rst && m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL pop_unexpected: got %0h, expected no data", m_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("pop_data", 32'(m_data), 32'(mon_e));
                end
            end
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // Pulse rx_done for one byte; accepted bytes are queued as expected data.
    task automatic send_byte(input logic [DATA_W-1:0] b, input bit accept);
        @(negedge clk);
        rx_data = b;
        rx_done = 1'b1;
        if (accept) exp_q.push_back(b);
        repeat (4) @(negedge clk);
        rx_done = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // Drain with random host readiness, then poke an empty FIFO.
    task automatic drain();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) break;
            m_ready = 1'($urandom_range(0, 1));
        end
        m_ready = 1'b1;
        repeat (3) @(negedge clk);
        m_ready = 1'b0;
        check("drain_level", 32'(fifo_level), 0);
        check("drain_valid", 32'(m_valid), 0);
        check("drain_queue", exp_q.size(), 0);
    endtask

    initial begin
        rst         = 1'b1;
        cfg_en      = 1'b0;
        cfg_div     = '0;
        rx_line     = 1'b1;
        rx_done     = 1'b0;
        rx_data     = '0;
        m_ready     = 1'b0;
        clr_overrun = 1'b0;
        #12;
        check("rst_tick", 32'(rx_tick), 0);
        check("rst_ena", 32'(rx_ena), 0);
        check("rst_valid", 32'(m_valid), 0);
        check("rst_data", 32'(m_data), 0);
        check("rst_level", 32'(fifo_level), 0);
        check("rst_overrun", 32'(overrun), 0);
        check("rst_timeout", 32'(rx_timeout), 0);
        @(negedge clk);
        rst = 1'b0;

        // Tick period 5 and 16 idle ticks before enable.
        cfg_div    = 16'd5;
        cfg_en     = 1'b1;
        ticks      = 0;
        cyc        = 0;
        last_tick  = -1;
        tick16_cyc = -1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            cyc++;
            if (rx_ena) break;
            if (rx_tick) begin
                ticks++;
                if (last_tick >= 0 && ticks <= 4) check("tick_period_5", cyc - last_tick, 5);
                if (ticks == 16) tick16_cyc = cyc;
                last_tick = cyc;
            end
        end
        check("arm_ena", 32'(rx_ena), 1);
        check("arm_ticks", ticks, 16);
        check("arm_latency", cyc - tick16_cyc, 1);

        // Divisor 0 behaves as 1: a tick every clock.
        cfg_div = '0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            check("tick_div0", 32'(rx_tick), 1);
            @(negedge clk);
        end

        // Idle qualification restarts once the line goes high.
        cfg_en = 1'b0;
        @(negedge clk);
        check("off_ena", 32'(rx_ena), 0);
        cfg_div = 16'd3;
        rx_line = 1'b0;
        cfg_en  = 1'b1;
        ticks   = 0;
        for (int i = 0; i < 200 && ticks < 10; i++) begin
            @(negedge clk);
            if (rx_tick) ticks++;
            if (rx_ena) break;
        end
        check("low_ticks", ticks, 10);
        check("low_no_ena", 32'(rx_ena), 0);
        rx_line = 1'b1;
        ticks   = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (rx_ena) break;
            if (rx_tick) ticks++;
        end
        check("release_ena", 32'(rx_ena), 1);
        check("release_ticks", ticks, 16);

        // Capture latency of a single byte.
        @(negedge clk);
        rx_data = 8'hA5;
        rx_done = 1'b1;
        exp_q.push_back(8'hA5);
        @(negedge clk);
        @(negedge clk);
        check("lat_valid_early", 32'(m_valid), 0);
        @(negedge clk);
        check("lat_valid", 32'(m_valid), 1);
        check("lat_data", 32'(m_data), 32'h0A5);
        check("lat_level", 32'(fifo_level), 1);
        repeat (2) @(negedge clk);
        rx_done = 1'b0;
        repeat (2) @(negedge clk);
        drain();

        // Overrun: five bytes into four entries.
        for (int i = 0; i < 5; i++) begin
            d = 8'(8'h11 * (i + 1));
            send_byte(d, (i < 4));
        end
        check("ovr_level", 32'(fifo_level), 4);
        check("ovr_flag", 32'(overrun), 1);
        clr_overrun = 1'b1;
        @(negedge clk);
        clr_overrun = 1'b0;
        check("ovr_clear", 32'(overrun), 0);

        // A drop coinciding with clear keeps the flag.
        @(negedge clk);
        rx_data = 8'h66;
        rx_done = 1'b1;
        @(negedge clk);
        @(negedge clk);
        clr_overrun = 1'b1;
        @(negedge clk);
        clr_overrun = 1'b0;
        check("ovr_clr_race", 32'(overrun), 1);
        check("ovr_clr_level", 32'(fifo_level), 4);
        rx_done = 1'b0;
        repeat (2) @(negedge clk);
        clr_overrun = 1'b1;
        @(negedge clk);
        clr_overrun = 1'b0;

        // Push and pop together while full.
        @(negedge clk);
        rx_data = 8'h77;
        rx_done = 1'b1;
        exp_q.push_back(8'h77);
        @(negedge clk);
        @(negedge clk);
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
        check("full_pp_level", 32'(fifo_level), 4);
        check("full_pp_ovr", 32'(overrun), 0);
        rx_done = 1'b0;
        repeat (2) @(negedge clk);
        drain();

        // Randomized bursts against the occupancy model.
        for (int it = 0; it < 6; it++) begin
            cfg_div = 16'($urandom_range(0, 7));
            n_bytes = $urandom_range(1, 6);
            ovr_exp = 1'b0;
            for (int i = 0; i < n_bytes; i++) begin
                d   = 8'($urandom);
                acc = (exp_q.size() < DEPTH);
                if (!acc) ovr_exp = 1'b1;
                send_byte(d, acc);
            end
            check("rnd_level", 32'(fifo_level), exp_q.size());
            check("rnd_ovr", 32'(overrun), 32'(ovr_exp));
            clr_overrun = 1'b1;
            @(negedge clk);
            clr_overrun = 1'b0;
            drain();
        end

        // Receive-idle timeout with a byte left unread.
        cfg_div = '0;
        send_byte(8'h3C, 1'b1);
        repeat (700) @(negedge clk);
`ifdef UART_RX_TIMEOUT_EN
        timeout_exp = 1'b1;
`else
        timeout_exp = 1'b0;
`endif
        check("timeout_flag", 32'(rx_timeout), 32'(timeout_exp));
        drain();
        check("timeout_clear", 32'(rx_timeout), 0);

        // Disable mid-operation keeps queued bytes, then async reset.
        send_byte(8'h5A, 1'b1);
        send_byte(8'hC3, 1'b1);
        cfg_en = 1'b0;
        @(negedge clk);
        check("dis_ena", 32'(rx_ena), 0);
        check("dis_level", 32'(fifo_level), 2);
        check("dis_valid", 32'(m_valid), 1);
        check("dis_data", 32'(m_data), 32'(exp_q[0]));
        #1;
        rst = 1'b1;
        #1;
        exp_q.delete();
        check("arst_tick", 32'(rx_tick), 0);
        check("arst_ena", 32'(rx_ena), 0);
        check("arst_valid", 32'(m_valid), 0);
        check("arst_data", 32'(m_data), 0);
        check("arst_level", 32'(fifo_level), 0);
        check("arst_overrun", 32'(overrun), 0);
        check("arst_timeout", 32'(rx_timeout), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
